// File: rtl/fp_adder_wb_slave.sv
// Wishbone classic responder that loads FP adder operands, launches an add,
// tracks busy/done/timeout and returns the core result with a level interrupt.
module fp_adder_wb_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] fp_a,
  output logic [31:0] fp_b,
  output logic        fp_start,
  input  logic        fp_done,
  input  logic [31:0] fp_result,
  output logic        irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] OFF_OP_A   = 3'd0;
  localparam logic [2:0] OFF_OP_B   = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_RESULT = 3'd4;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [DATA_W-1:0]   result, result_nx;
  logic                irq_en, irq_en_nx;
  logic                done, done_nx;
  logic                timeout, timeout_nx;
  logic                start_nx;
  logic                irq_nx;
  logic [DATA_W-1:0]   rdata;

  logic       hit, take, wr, busy, ctrl_wr, status_wr, start_req, op_wr_ok;
  logic [2:0] offset;
  logic       unused_ok;

  assign unused_ok = ^wbs_adr_i[1:0];

  // Address decode and single-cycle access qualification
  assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign take      = hit & ~wbs_ack_o;
  assign wr        = take & wbs_we_i;
  assign offset    = wbs_adr_i[4:2];
  assign busy      = (state == S_RUN);
  assign ctrl_wr   = wr & (offset == OFF_CTRL) & wbs_sel_i[0];
  assign status_wr = wr & (offset == OFF_STATUS) & wbs_sel_i[0];
  assign start_req = ctrl_wr & wbs_dat_i[0];
  assign op_wr_ok  = wr & ~busy;

  // Read data mux; START reads back as zero
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_OP_A:   rdata = fp_a;
      OFF_OP_B:   rdata = fp_b;
      OFF_CTRL:   rdata = {30'd0, irq_en, 1'b0};
      OFF_STATUS: rdata = {29'd0, timeout, done, busy};
      OFF_RESULT: rdata = result;
      default:    rdata = '0;
    endcase
  end

  // Next-state and flag logic; core completion is applied after W1C so a set wins
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    result_nx  = result;
    irq_en_nx  = irq_en;
    done_nx    = done;
    timeout_nx = timeout;
    start_nx   = 1'b0;

    if (ctrl_wr) begin
      irq_en_nx = wbs_dat_i[1];
    end
    if (status_wr) begin
      if (wbs_dat_i[1]) done_nx    = 1'b0;
      if (wbs_dat_i[2]) timeout_nx = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (start_req) begin
          start_nx   = 1'b1;
          done_nx    = 1'b0;
          timeout_nx = 1'b0;
          cnt_nx     = '0;
          state_nx   = S_RUN;
        end
      end
      S_RUN: begin
        cnt_nx = cnt + CNT_W'(1);
        if (fp_done) begin
          result_nx = fp_result;
          done_nx   = 1'b1;
          state_nx  = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_nx = 1'b1;
          state_nx   = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    irq_nx = irq_en_nx & (done_nx | timeout_nx);
  end

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Control/status registers, start pulse and interrupt
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt      <= '0;
      result   <= '0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      fp_start <= 1'b0;
      irq      <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      result   <= result_nx;
      irq_en   <= irq_en_nx;
      done     <= done_nx;
      timeout  <= timeout_nx;
      fp_start <= start_nx;
      irq      <= irq_nx;
    end
  end

  // Operand registers with byte-lane writes, frozen while the core is busy
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      fp_a <= '0;
      fp_b <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (op_wr_ok && offset == OFF_OP_A && wbs_sel_i[i]) fp_a[8*i +: 8] <= wbs_dat_i[8*i +: 8];
        if (op_wr_ok && offset == OFF_OP_B && wbs_sel_i[i]) fp_b[8*i +: 8] <= wbs_dat_i[8*i +: 8];
      end
    end
  end

  // Bus response: one-cycle ack, data zero whenever ack is low
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= take;
      wbs_dat_o <= take ? rdata : '0;
    end
  end

endmodule
